cp0_exception_commit: RTL

CP0 register bank and exception commit unit for the GenshinCPU MEM stage.
- Consumes the final exception vector and the `IsExceptionOrEret` redirect class produced by MEM-stage exception detection.
- Commits the architectural side effects: EPC, Cause, Status.EXL and BadVAddr.
- Returns the redirect PC, plus Status/Cause, back to the detector.
- Also owns the Count/Compare timer and serves MTC0/MFC0 accesses.

---
 rtl/cp0_exception_commit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_exception_commit.sv
// CP0 register bank and exception commit for the MEM stage: EPC/Cause/Status/BadVAddr
// side effects, redirect PC generation, MTC0/MFC0, and the optional CP0_TIMER_INT_EN timer.
package cp0_pkg;
    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic TLBRefill;
        logic TLBInvalid;
        logic ReservedInstruction;
        logic Overflow;
        logic Trap;
        logic Syscall;
        logic Break;
        logic RdWrongAddressinMEM;
        logic WrWrongAddressinMEM;
        logic TLBModified;
    } ExceptinPipeType;

    localparam logic [1:0] IsNone      = 2'd0;
    localparam logic [1:0] IsException = 2'd1;
    localparam logic [1:0] IsEret      = 2'd2;
    localparam logic [1:0] IsRefetch   = 2'd3;
endpackage

module cp0_exception_commit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VEC_BEV  = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VEC_NORM = 32'h8000_0180
) (
    input  logic            clk,
    input  logic            rst,
    input  ExceptinPipeType MEM_ExceptType_final,
    input  logic [1:0]      IsExceptionOrEret,
    input  logic [31:0]     MEM_PC,
    input  logic            MEM_IsInDelaySlot,
    input  logic            MEM_IsStore,
    input  logic [31:0]     MEM_DataAddr,
    input  logic [5:0]      Ext_Int,
    input  logic            CP0_WrEn,
    input  logic [4:0]      CP0_WrAddr,
    input  logic [31:0]     CP0_WrData,
    input  logic [4:0]      CP0_RdAddr,
    output logic [31:0]     CP0_RdData,
    output logic [31:0]     CP0_Status,
    output logic [31:0]     CP0_Cause,
    output logic [31:0]     CP0_EPC,
    output logic [31:0]     Exc_NPC
);
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic        status_bev;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic        exc_commit;
    logic        eret_commit;
    logic        mtc0_en;
    logic [4:0]  exc_code;
    logic        badv_we;
    logic        badv_from_pc;
    logic        is_refill;
    logic [31:0] vec_base;

    assign exc_commit  = (IsExceptionOrEret == IsException);
    assign eret_commit = (IsExceptionOrEret == IsEret);
    // The pipeline flushes an MTC0 that collides with a commit, so its write is dropped here.
    assign mtc0_en     = CP0_WrEn & ~exc_commit & ~eret_commit;
    assign vec_base    = status_bev ? EXC_VEC_BEV : EXC_VEC_NORM;

    always_comb begin
        exc_code     = 5'h00;
        badv_we      = 1'b0;
        badv_from_pc = 1'b0;
        is_refill    = 1'b0;
        if (MEM_ExceptType_final.Interrupt) begin
            exc_code = 5'h00;
        end else if (MEM_ExceptType_final.WrongAddressinIF) begin
            exc_code     = 5'h04;
            badv_we      = 1'b1;
            badv_from_pc = 1'b1;
        end else if (MEM_ExceptType_final.TLBRefill | MEM_ExceptType_final.TLBInvalid) begin
            exc_code  = MEM_IsStore ? 5'h03 : 5'h02;
            badv_we   = 1'b1;
            is_refill = MEM_ExceptType_final.TLBRefill;
        end else if (MEM_ExceptType_final.ReservedInstruction) begin
            exc_code = 5'h0A;
        end else if (MEM_ExceptType_final.Overflow) begin
            exc_code = 5'h0C;
        end else if (MEM_ExceptType_final.Trap) begin
            exc_code = 5'h0D;
        end else if (MEM_ExceptType_final.Syscall) begin
            exc_code = 5'h08;
        end else if (MEM_ExceptType_final.Break) begin
            exc_code = 5'h09;
        end else if (MEM_ExceptType_final.RdWrongAddressinMEM) begin
            exc_code = 5'h04;
            badv_we  = 1'b1;
        end else if (MEM_ExceptType_final.WrWrongAddressinMEM) begin
            exc_code = 5'h05;
            badv_we  = 1'b1;
        end else if (MEM_ExceptType_final.TLBModified) begin
            exc_code = 5'h01;
            badv_we  = 1'b1;
        end
    end

    always_comb begin
        Exc_NPC = 32'h0;
        if (rst) begin
            case (IsExceptionOrEret)
                IsException: Exc_NPC = (is_refill && !status_exl) ? vec_base - 32'h180 : vec_base;
                IsEret:      Exc_NPC = epc;
                IsRefetch:   Exc_NPC = MEM_PC;
                default:     Exc_NPC = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_bev <= 1'b1;
            status_im  <= 8'h0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else begin
            if (mtc0_en && CP0_WrAddr == ADDR_STATUS) begin
                status_bev <= CP0_WrData[22];
                status_im  <= CP0_WrData[15:8];
                status_exl <= CP0_WrData[1];
                status_ie  <= CP0_WrData[0];
            end
            if (exc_commit)
                status_exl <= 1'b1;
            else if (eret_commit)
                status_exl <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cause_bd      <= 1'b0;
            cause_ip_hw   <= 6'h0;
            cause_ip_sw   <= 2'h0;
            cause_exccode <= 5'h0;
            epc           <= 32'h0;
            badvaddr      <= 32'h0;
        end else begin
            cause_ip_hw <= {Ext_Int[5] | ti, Ext_Int[4:0]};
            if (mtc0_en && CP0_WrAddr == ADDR_CAUSE)
                cause_ip_sw <= CP0_WrData[9:8];
            if (mtc0_en && CP0_WrAddr == ADDR_EPC)
                epc <= CP0_WrData;
            if (exc_commit) begin
                cause_exccode <= exc_code;
                // A nested exception keeps the original return point.
                if (!status_exl) begin
                    cause_bd <= MEM_IsInDelaySlot;
                    epc      <= MEM_IsInDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                end
                if (badv_we)
                    badvaddr <= badv_from_pc ? MEM_PC : MEM_DataAddr;
            end
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic presc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= 32'h0;
            compare <= 32'h0;
            presc   <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (mtc0_en && CP0_WrAddr == ADDR_COUNT) begin
                count <= CP0_WrData;
                presc <= 1'b0;
            end else begin
                presc <= ~presc;
                if (presc)
                    count <= count + 32'd1;
            end
            // A Compare write acknowledges the timer and beats a simultaneous match.
            if (mtc0_en && CP0_WrAddr == ADDR_COMPARE) begin
                compare <= CP0_WrData;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign count   = 32'h0;
    assign compare = 32'h0;
    assign ti      = 1'b0;
`endif

    assign CP0_Status = {9'h0, status_bev, 6'h0, status_im, 6'h0, status_exl, status_ie};
    assign CP0_Cause  = {cause_bd, ti, 14'h0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exccode, 2'b00};
    assign CP0_EPC    = epc;

    always_comb begin
        case (CP0_RdAddr)
            ADDR_BADVADDR: CP0_RdData = badvaddr;
            ADDR_COUNT:    CP0_RdData = count;
            ADDR_COMPARE:  CP0_RdData = compare;
            ADDR_STATUS:   CP0_RdData = CP0_Status;
            ADDR_CAUSE:    CP0_RdData = CP0_Cause;
            ADDR_EPC:      CP0_RdData = epc;
            default:       CP0_RdData = 32'h0;
        endcase
    end
endmodule
